// File: rtl/variable_node_penalty_lanes.sv
// Multi-lane variable-node penalty (bypass / L1 / L2) for the ADMM-LP decoder.
// Three registered stages: capture, penalty term, saturating add.
module variable_node_penalty_lanes #(
    parameter int TAG_WIDTH      = 32,
    parameter int DATA_WIDTH     = 18,
    parameter int FRACTION_WIDTH = 10,
    parameter int NUM_LANES      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    output logic                              ready_out,
    input  logic [TAG_WIDTH-1:0]              tag_in,
    input  logic [1:0]                        mode,
    input  logic [DATA_WIDTH-1:0]             penaltyParam,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   prePenalty,
    input  logic                              ready_in,
    output logic                              valid_out,
    output logic [TAG_WIDTH-1:0]              tag_out,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   postPenalty,
    output logic [NUM_LANES-1:0]              sat_out,
    output logic                              busy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int W  = 2 * DATA_WIDTH - FRACTION_WIDTH + 1;

    logic                            enable;

    logic                            s1_valid;
    logic [TAG_WIDTH-1:0]            s1_tag;
    logic [1:0]                      s1_mode;
    logic [DATA_WIDTH-1:0]           s1_p;
    logic [NUM_LANES*DATA_WIDTH-1:0] s1_x;

    logic                            s2_valid;
    logic [TAG_WIDTH-1:0]            s2_tag;
    logic [NUM_LANES*DATA_WIDTH-1:0] s2_x;
    logic [NUM_LANES*W-1:0]          s2_t;

    logic [NUM_LANES*W-1:0]          t_next;
    logic [NUM_LANES*DATA_WIDTH-1:0] res_next;
    logic [NUM_LANES-1:0]            sat_next;

    assign enable    = ready_in | ~valid_out;
    assign ready_out = enable;
    assign busy      = s1_valid | s2_valid | valid_out;

    always_comb begin : s2_terms
        logic signed [DATA_WIDTH-1:0] x;
        logic signed [PW-1:0]         prod;
        logic signed [W-1:0]          p_ext;
        logic signed [W-1:0]          t;
        t_next = '0;
        x      = '0;
        prod   = '0;
        t      = '0;
        p_ext  = {{(W-DATA_WIDTH){s1_p[DATA_WIDTH-1]}}, s1_p};
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            x    = s1_x[i*DATA_WIDTH +: DATA_WIDTH];
            // Operands sign-extended to full product width so the low PW bits are the signed product
            prod = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x} *
                   {{DATA_WIDTH{s1_p[DATA_WIDTH-1]}}, s1_p};
            case (s1_mode)
                2'b01:   t = x[DATA_WIDTH-1] ? -p_ext : p_ext;
                2'b10:   t = W'(prod >>> FRACTION_WIDTH);
                default: t = '0;
            endcase
            t_next[i*W +: W] = t;
        end
    end

    always_comb begin : s3_sum
        logic [DATA_WIDTH-1:0] x;
        logic [W-1:0]          t;
        logic [W:0]            s;
        res_next = '0;
        sat_next = '0;
        x        = '0;
        t        = '0;
        s        = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            x = s2_x[i*DATA_WIDTH +: DATA_WIDTH];
            t = s2_t[i*W +: W];
            s = {{(W+1-DATA_WIDTH){x[DATA_WIDTH-1]}}, x} + {t[W-1], t};
            // In range only when every bit above the result MSB matches the sign
            if (!s[W] && (|s[W-1:DATA_WIDTH-1])) begin
                res_next[i*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                sat_next[i] = 1'b1;
            end else if (s[W] && !(&s[W-1:DATA_WIDTH-1])) begin
                res_next[i*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                sat_next[i] = 1'b1;
            end else begin
                res_next[i*DATA_WIDTH +: DATA_WIDTH] = s[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_tag      <= '0;
            s1_mode     <= '0;
            s1_p        <= '0;
            s1_x        <= '0;
            s2_valid    <= 1'b0;
            s2_tag      <= '0;
            s2_x        <= '0;
            s2_t        <= '0;
            valid_out   <= 1'b0;
            tag_out     <= '0;
            postPenalty <= '0;
            sat_out     <= '0;
        end else if (enable) begin
            s1_valid    <= valid_in;
            s1_tag      <= tag_in;
            s1_mode     <= mode;
            s1_p        <= penaltyParam;
            s1_x        <= prePenalty;
            s2_valid    <= s1_valid;
            s2_tag      <= s1_tag;
            s2_x        <= s1_x;
            s2_t        <= t_next;
            valid_out   <= s2_valid;
            tag_out     <= s2_tag;
            postPenalty <= res_next;
            sat_out     <= sat_next;
        end
    end

endmodule

// File: tb/tb_variable_node_penalty_lanes.sv
// Self-checking bench for variable_node_penalty_lanes: directed examples plus
// randomized traffic against an integer-arithmetic scoreboard.
module tb_variable_node_penalty_lanes;

    localparam int DW = 18;
    localparam int FW = 10;
    localparam int NL = 4;
    localparam int TW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             valid_in;
    logic             ready_out;
    logic [TW-1:0]    tag_in;
    logic [1:0]       mode;
    logic [DW-1:0]    penaltyParam;
    logic [NL*DW-1:0] prePenalty;
    logic             ready_in;
    logic             valid_out;
    logic [TW-1:0]    tag_out;
    logic [NL*DW-1:0] postPenalty;
    logic [NL-1:0]    sat_out;
    logic             busy;

    variable_node_penalty_lanes #(
        .TAG_WIDTH(TW), .DATA_WIDTH(DW), .FRACTION_WIDTH(FW), .NUM_LANES(NL)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .tag_in(tag_in), .mode(mode), .penaltyParam(penaltyParam),
        .prePenalty(prePenalty), .ready_in(ready_in), .valid_out(valid_out),
        .tag_out(tag_out), .postPenalty(postPenalty), .sat_out(sat_out),
        .busy(busy)
    );

    typedef struct {
        logic [TW-1:0]    tag;
        logic [NL*DW-1:0] post;
        logic [NL-1:0]    sat;
        int               acc;
        bit               stalled;
    } exp_t;

    exp_t             q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               step_n   = 0;
    bit               prev_stall = 1'b0;
    logic [TW-1:0]    snap_tag;
    logic [NL*DW-1:0] snap_post;
    logic [NL-1:0]    snap_sat;
    logic [TW-1:0]    last_tag;
    logic [NL*DW-1:0] last_post;
    logic [NL-1:0]    last_sat;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, req);
        end
    endtask

    // Reference: plain integer arithmetic, floor division for L2, clamp to DW bits
    function automatic void model(input logic [1:0] m, input logic [DW-1:0] p,
                                  input logic [NL*DW-1:0] x,
                                  output logic [NL*DW-1:0] post, output logic [NL-1:0] sat);
        logic signed [DW-1:0] xs;
        logic signed [DW-1:0] ps;
        longint xi, pi, t, s;
        longint maxv, minv;
        maxv = (longint'(1) <<< (DW-1)) - 1;
        minv = -(longint'(1) <<< (DW-1));
        ps = p;
        pi = ps;
        post = '0;
        sat  = '0;
        for (int i = 0; i < NL; i++) begin
            xs = x[i*DW +: DW];
            xi = xs;
            if (m == 2'b01)      t = (xi >= 0) ? pi : -pi;
            else if (m == 2'b10) t = (xi * pi) >>> FW;
            else                 t = 0;
            s = xi + t;
            if (s > maxv)      begin s = maxv; sat[i] = 1'b1; end
            else if (s < minv) begin s = minv; sat[i] = 1'b1; end
            post[i*DW +: DW] = s[DW-1:0];
        end
    endfunction

    function automatic logic [NL*DW-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                               input logic [DW-1:0] l2, input logic [DW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [NL*DW-1:0] rand_lanes();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[NL*DW-1:0];
    endfunction

    task automatic step(input bit vin, input logic [1:0] m, input logic [DW-1:0] p,
                        input logic [NL*DW-1:0] x, input logic [TW-1:0] tg, input bit rdy);
        exp_t e;
        @(negedge clk);
        valid_in     = vin;
        mode         = m;
        penaltyParam = p;
        prePenalty   = x;
        tag_in       = tg;
        ready_in     = rdy;
        #1;
        if (valid_out && !ready_in) begin
            check("stall_ready_out", 128'(ready_out), 128'(0));
            if (prev_stall) begin
                check("stall_tag", 128'(tag_out), 128'(snap_tag));
                check("stall_post", 128'(postPenalty), 128'(snap_post));
                check("stall_sat", 128'(sat_out), 128'(snap_sat));
            end
            prev_stall = 1'b1;
            snap_tag   = tag_out;
            snap_post  = postPenalty;
            snap_sat   = sat_out;
            foreach (q[i]) q[i].stalled = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
        if (valid_out && ready_in) begin
            check("output_expected", 128'(q.size() != 0), 128'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("tag", 128'(tag_out), 128'(e.tag));
                check("post", 128'(postPenalty), 128'(e.post));
                check("sat", 128'(sat_out), 128'(e.sat));
                if (!e.stalled) check("latency", 128'(step_n - e.acc), 128'(3));
                last_tag  = tag_out;
                last_post = postPenalty;
                last_sat  = sat_out;
            end
        end
        if (vin && ready_out) begin
            e.tag     = tg;
            model(m, p, x, e.post, e.sat);
            e.acc     = step_n;
            e.stalled = 1'b0;
            q.push_back(e);
        end
        step_n++;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, '0, '0, '0, 1'b1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            idle();
            guard++;
        end
        check("drain_complete", 128'(q.size()), 128'(0));
        idle();
        check("busy_idle", 128'(busy), 128'(0));
        check("valid_idle", 128'(valid_out), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NL*DW-1:0] x2;
        logic [DW-1:0]    p;
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; mode = '0;
        penaltyParam = '0; prePenalty = '0; tag_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 128'(valid_out), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_post", 128'(postPenalty), 128'(0));
        check("rst_tag", 128'(tag_out), 128'(0));
        check("rst_sat", 128'(sat_out), 128'(0));
        check("rst_ready_out", 128'(ready_out), 128'(1));
        reset = 1'b0;
        step(1'b0, 2'b00, '0, '0, '0, 1'b0);
        check("idle_ready_out", 128'(ready_out), 128'(1));

        // L1 example
        step(1'b1, 2'b01, 18'd256, pack4(18'sd100, -18'sd100, 18'sd0, -18'sd1), 32'hA5A5_0001, 1'b1);
        repeat (3) idle();
        check("l1_post", 128'(last_post), 128'(pack4(18'sd356, -18'sd356, 18'sd256, -18'sd257)));
        check("l1_sat", 128'(last_sat), 128'(0));
        check("l1_tag", 128'(last_tag), 128'(32'hA5A5_0001));

        // L2 example
        step(1'b1, 2'b10, 18'd256, pack4(18'sd1024, -18'sd3, 18'sd4096, 18'sd0), 32'hA5A5_0002, 1'b1);
        repeat (3) idle();
        check("l2_post", 128'(last_post), 128'(pack4(18'sd1280, -18'sd4, 18'sd5120, 18'sd0)));
        check("l2_sat", 128'(last_sat), 128'(0));

        // Bypass, both encodings
        step(1'b1, 2'b00, 18'd777, rand_lanes(), 32'hA5A5_0003, 1'b1);
        x2 = rand_lanes();
        step(1'b1, 2'b11, 18'd777, x2, 32'hA5A5_0004, 1'b1);
        repeat (3) idle();
        check("bypass11_post", 128'(last_post), 128'(x2));

        // Saturation, L1 then L2
        step(1'b1, 2'b01, 18'd1000, pack4(18'sd131000, -18'sd131000, 18'sd130071, -18'sd130072),
             32'hA5A5_0005, 1'b1);
        repeat (3) idle();
        check("satl1_post", 128'(last_post), 128'(pack4(18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h20000)));
        check("satl1_sat", 128'(last_sat), 128'(4'b0011));
        step(1'b1, 2'b10, 18'd1024, pack4(18'sd100000, 18'sd0, -18'sd5, 18'sd7), 32'hA5A5_0006, 1'b1);
        repeat (3) idle();
        check("satl2_lane0", 128'(last_post[DW-1:0]), 128'(18'h1FFFF));
        check("satl2_sat0", 128'(last_sat[0]), 128'(1));
        drain();

        // Back-to-back, alternating modes
        for (int k = 0; k < 5; k++)
            step(1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 18'($urandom_range(0, 4095)),
                 rand_lanes(), 32'hB000 + 32'(k), 1'b1);
        drain();

        // Backpressure after the first output
        for (int k = 0; k < 16; k++)
            step(k < 12, 2'($urandom_range(1, 2)), 18'($urandom_range(0, 4095)),
                 rand_lanes(), 32'hC000 + 32'(k), !(k >= 4 && k < 10));
        drain();

        // Randomized traffic, including occasional negative penalty
        for (int k = 0; k < 400; k++) begin
            if (k % 16 == 0) p = -18'($urandom_range(1, 4096));
            else             p = 18'($urandom_range(0, 8192));
            step(($urandom() % 4) != 0, 2'($urandom_range(0, 3)), p, rand_lanes(),
                 $urandom(), ($urandom() % 4) != 0);
        end
        drain();

        // Reset with transactions in flight
        for (int k = 0; k < 3; k++)
            step(1'b1, 2'b01, 18'd256, rand_lanes(), 32'hD000 + 32'(k), 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        check("pre_reset_valid", 128'(valid_out), 128'(1));
        check("pre_reset_busy", 128'(busy), 128'(1));
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_valid", 128'(valid_out), 128'(0));
        check("mid_rst_post", 128'(postPenalty), 128'(0));
        check("mid_rst_tag", 128'(tag_out), 128'(0));
        check("mid_rst_sat", 128'(sat_out), 128'(0));
        check("mid_rst_ready", 128'(ready_out), 128'(1));
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle();
            check("post_rst_no_output", 128'(valid_out), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/variable_node_penalty_lanes.md
# variable_node_penalty_lanes

Multi-lane, mode-selectable successor to the single-lane centered L1 variable-node penalty in the ADMM-LP decoder. Applies a per-transaction penalty (bypass, L1, or L2) to NUM_LANES centered fixed-point pre-penalty values in a 3-stage pipeline. Results are saturated to DATA_WIDTH and carry a per-lane saturation flag. The block sits between the variable-node averaging stage and the check-node message update, using the codebase's valid/ready/busy/tag pipeline handshake.

## Interface
- TAG_WIDTH, 32, width of the opaque tag carried alongside the data
- DATA_WIDTH, 18, signed fixed-point width of each lane value and of the penalty parameter
- FRACTION_WIDTH, 10, fractional bits of the fixed-point format
- NUM_LANES, 4, number of parallel lanes; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

- clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- valid_in  in  1  upstream presents a transaction
- ready_out  out  1  block accepts a transaction this cycle
- tag_in  in  TAG_WIDTH  tag associated with the transaction
- mode  in  2  00 bypass, 01 L1, 10 L2, 11 treated as bypass
- penaltyParam  in  DATA_WIDTH  signed, non-negative by contract
- prePenalty  in  NUM_LANES*DATA_WIDTH  packed signed lane inputs
- ready_in  in  1  downstream can take the output this cycle
- valid_out  out  1  output holds a valid transaction
- tag_out  out  TAG_WIDTH  tag of the output transaction
- postPenalty  out  NUM_LANES*DATA_WIDTH  packed signed results
- sat_out  out  NUM_LANES  per-lane flag; set when that lane's result was clamped
- busy  out  1  at least one pipeline stage holds a valid transaction

## Operation
- Global advance: enable = ready_in | ~valid_out. ready_out = enable.
- An input transfer occurs when valid_in & ready_out. An output transfer occurs when valid_out & ready_in.
- While enable is high, every stage (data, tag, valid bit) shifts forward one position. While enable is low, all stages hold.
- S1 registers the tag, mode, penaltyParam and all lanes. Mode and penaltyParam are therefore per-transaction; later input changes never affect in-flight data.
- S2 computes a per-lane term T at width W = 2*DATA_WIDTH-FRACTION_WIDTH+1:
  - Bypass: T = 0.
  - L1: T = +p if x >= 0, otherwise T = -p. Zero counts as non-negative.
  - L2: T = (x*p) >>> FRACTION_WIDTH, using a full-width signed product and an arithmetic shift (rounds toward -inf).
- S2 also forwards x.
- S3 computes S = x + T at W+1 bits. If S > 2^(DATA_WIDTH-1)-1, the output is that maximum and sat=1. If S < -2^(DATA_WIDTH-1), the output is that minimum and sat=1. Otherwise the output is S[DATA_WIDTH-1:0] and sat=0.
- Lanes are fully independent. There is no cross-lane arithmetic.
- busy = S1.valid | S2.valid | S3.valid.
- A negative penaltyParam is out of contract, but it must still produce the deterministic arithmetic result defined above, with no X.

## Timing
- Reset, asynchronous and effective immediately: all valid bits = 0, all data/tag/sat registers = 0, valid_out = 0, busy = 0, postPenalty = 0, tag_out = 0, sat_out = 0, ready_out = 1.
- Reset mid-operation discards all in-flight transactions, with no partial output.
- Latency: a transaction accepted at edge k appears on valid_out after edge k+2, i.e. three registered stages. It is presented from the cycle following the 3rd edge, provided no stall occurs.
- Throughput: one transaction per cycle while ready_in = 1.
- Stall: while valid_out = 1 and ready_in = 0, valid_out, tag_out, postPenalty and sat_out must remain stable, and ready_out = 0.
- When valid_out = 0, the pipeline advances regardless of ready_in, so bubbles are filled.
- When an output is consumed and a new input is accepted in the same cycle, both transfers happen on that edge.
- Outputs are registered. There is no combinational path from prePenalty, mode or penaltyParam to any output.
- ready_out depends combinationally on ready_in and valid_out.

## Test plan
- **Reset:** assert reset for 3 cycles, then release. All outputs are 0 and ready_out = 1. Assert reset again while 3 transactions are in flight: busy and valid_out drop immediately, and no outputs appear afterwards.
- **L1 values**, mode=01, p=256 (0.25), lanes {100, -100, 0, -1} -> {356, -356, 256, -257}, sat=0000, three cycles after acceptance with the tag preserved.
- **L2 values**, mode=10, p=256: lanes {1024, -3, 4096, 0} -> {1280, -4, 5120, 0}, sat=0000. Bypass, mode=00 or 11, returns the inputs unchanged.
- **Saturation**, L1 with p=1000: lanes {131000, -131000, 130071, -130072} -> {131071, -131072, 131071, -131072}, sat=1100. L2 with p=1024 and x=100000 -> 131071, sat=1.
- **Back-to-back with per-transaction mode:** 5 consecutive inputs alternating modes 01/10 with differing p and tags, ready_in=1. Five consecutive outputs, each computed with its own mode and p, tags in order.
- **Backpressure:** hold ready_in=0 after the 1st output with a continuous input stream. The pipeline fills (3 accepted), ready_out=0, and the output stays stable. Release ready_in: all transactions drain in order with no loss or duplication, and busy falls to 0 after the last transfer.
